car_physics_multi: RTL and testbench
====================================

CAR_PHYSICS_MULTI -- requirements
Module: car_physics_multi

Interface (parameters: name, default, meaning)
REQ-001 SHALL have parameter NUM_OPP, 3: number of opponent cars scanned for collision (1..7).
REQ-002 SHALL have parameter FRAC_BITS, 10: fractional bits of the position accumulators.
REQ-003 SHALL have parameter TICK_DIV, 833333: clk cycles per game tick; TICK_DIV > NUM_OPP+4.
REQ-004 SHALL have parameters START_X, 0 and START_Y, 120: spawn position in pixels.
REQ-005 SHALL have parameters MAP_W, 320; MAP_H, 240; WALL_M, 6: map size and wall margin in pixels.
REQ-006 SHALL have parameters MAX_FWD, 6; MAX_REV, 4; BOUNCE, 3; ACCEL_DIV, 8; TURN_DELAY, 2: speed limits, bounce speed, ticks per speed step, ticks between steering steps.
REQ-007 SHALL have parameters SLOW_COLOR, 6; SLOW_MAX, 2: slow-surface colour code and speed cap.
REQ-008 SHALL have parameters HIT_R2, 36; HIT_CD, 30; WALL_CD, 20: squared hit radius and cooldown lengths in ticks.

Interface (ports: name, direction, width, meaning)
REQ-009 SHALL have clk input 1: clock; all logic on the rising edge.
REQ-010 SHALL have rst input 1: reset, synchronous, active-high.
REQ-011 SHALL have state input 3: game state (0 IDLE, 4 RACING; other codes hold).
REQ-012 SHALL have h_code input 2 (1 left, 2 right), v_code input 2 (1 accelerate, 2 brake/reverse), color input 4 (surface under car).
REQ-013 SHALL have opp_x and opp_y inputs 10*NUM_OPP: packed opponent centres, opponent k in bits [10k+9:10k]; opp_valid input NUM_OPP: per-opponent enable.
REQ-014 SHALL have pos_x and pos_y outputs 10 (rounded pixel position), angle_idx output 4, and speed_out output 8 (signed).
REQ-015 SHALL have hit_pulse, wall_pulse and tick_done outputs 1 (single-cycle pulses), hit_idx output 3, and busy output 1.

Function
REQ-016 SHALL generate a game tick when a free-running counter reaches TICK_DIV-1, then wrap to 0.
REQ-017 SHALL act on a tick only when state==RACING; ticks in any other state are ignored and all state is held.
REQ-018 SHALL run FSM WAIT -> SCAN -> APPLY -> WAIT: WAIT leaves on an accepted tick; SCAN lasts exactly NUM_OPP cycles; APPLY lasts 1 cycle and pulses tick_done; busy=1 outside WAIT.
REQ-019 SCAN SHALL test opponent k in cycle k: dx,dy = own integer position minus opponent, 11-bit signed; hit if opp_valid[k] and dx*dx+dy*dy < HIT_R2 (22-bit unsigned).
REQ-020 SHALL latch hit_idx as the lowest-index opponent that hit.
REQ-021 Steering SHALL use a 6-bit angle, decremented (left) or incremented (right) when its delay counter is 0, which then reloads TURN_DELAY, else decrements; counter clears when h_code is neither; angle_idx = angle[5:2]; 6-bit wrap is intended.
REQ-022 Target speed: when the accel divider (0..ACCEL_DIV-1, advances each applied tick) is 0: +1 up to MAX_FWD on accelerate, -1 down to -MAX_REV on brake, else move 1 toward 0; if color==SLOW_COLOR, clamp to +/-SLOW_MAX.
REQ-023 APPLY priority, in order: (a) cooldown>0: cooldown-1, speed <= friction-only target, position moves; (b) car hit: speed <= -BOUNCE if speed>=0 else +BOUNCE, cooldown <= HIT_CD, position held, hit_pulse; (c) wall (pos_x<WALL_M, >MAP_W-WALL_M, or same in y): same bounce, cooldown <= WALL_CD, wall_pulse; (d) normal: speed <= target, position moves.
REQ-024 Movement SHALL add (speed*dir)>>>2 (arithmetic) to a (10+FRAC_BITS)-bit signed accumulator per axis, dir being the Q8 unit vector for angle_idx (0=north, clockwise, +y down).
REQ-025 pos_x/pos_y SHALL be accumulator integer part plus bit FRAC_BITS-1 (round half up), registered at APPLY.
REQ-026 hit and wall pulses SHALL occur in the APPLY cycle, NUM_OPP+1 cycles after the accepted tick.

Reset
REQ-027 On rst, or in WAIT with state==IDLE: position START, speed 0, angle 0, all counters 0, FSM WAIT, pulses 0, hit_idx 0, busy 0.
REQ-028 rst asserted mid-SCAN SHALL abort the scan with no APPLY and no pulses.

Structure
REQ-029 Game-state codes, Q8 scale and the direction table width SHALL live in the shared race package.
REQ-030 The 16-entry direction table SHALL be the combinational sub-module dir_lut16.

Verification
REQ-031 Rest, RACING, v_code=1 held 48 ticks -> speed_out steps 1..6 every 8 ticks, holds 6.
REQ-032 angle_idx=4, speed 4 -> pos_x accumulator +256 per tick; pos_x +1 every 4 ticks.
REQ-033 NUM_OPP=3, opp 2 at own position, opp_valid=3'b111, speed 4 -> hit_pulse, hit_idx=2 at tick+4 cycles; speed -3; 30 cooldown ticks follow.
REQ-034 Same with opp_valid=3'b011 -> no hit_pulse, normal motion.
REQ-035 START_X=4, speed 0 -> wall_pulse on first tick, speed -3, cooldown 20.
REQ-036 state=PAUSE 1000 ticks mid-race -> pos, speed, angle unchanged; rst in SCAN cycle 1 -> no tick_done, outputs at reset values.

Source files
------------

// File: rtl/car_physics_multi_pkg.sv
// car_physics_multi_pkg: shared race types, Q8 scale, direction table width and helpers
package car_physics_multi_pkg;
    typedef enum logic [2:0] {GS_IDLE = 3'd0, GS_RACING = 3'd4} game_state_e;
    typedef enum logic [1:0] {ST_WAIT, ST_SCAN, ST_APPLY} phy_st_e;
    localparam int Q8 = 256;
    localparam int DIR_W = 10;
    typedef struct packed {
        logic signed [DIR_W-1:0] x;
        logic signed [DIR_W-1:0] y;
    } dir_t;
    function automatic logic signed [7:0] clamp8(input logic signed [7:0] v, input logic signed [7:0] lo, input logic signed [7:0] hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction
endpackage

// File: rtl/car_physics_multi_dir_lut16.sv
// dir_lut16: Q8 unit vector for 16 headings, 0 = north, clockwise, +y down
module dir_lut16
    import car_physics_multi_pkg::*;
(
    input  logic [3:0] i_idx,
    output dir_t       o_dir
);
    localparam int SIN [16] = '{0, 98, 181, 237, Q8, 237, 181, 98, 0, -98, -181, -237, -Q8, -237, -181, -98};
    logic [3:0] w_cos;
    // x = sin(heading), y = -cos(heading); cosine is the sine table shifted a quarter turn
    always_comb begin
        w_cos = i_idx + 4'd4;
        o_dir.x = DIR_W'(SIN[i_idx]);
        o_dir.y = DIR_W'(-SIN[w_cos]);
    end
endmodule

// File: rtl/car_physics_multi.sv
// car_physics_multi: per-tick car physics with opponent collision scan, walls and steering
module car_physics_multi
    import car_physics_multi_pkg::*;
#(
    parameter int NUM_OPP    = 3,
    parameter int FRAC_BITS  = 10,
    parameter int TICK_DIV   = 833333,
    parameter int START_X    = 0,
    parameter int START_Y    = 120,
    parameter int MAP_W      = 320,
    parameter int MAP_H      = 240,
    parameter int WALL_M     = 6,
    parameter int MAX_FWD    = 6,
    parameter int MAX_REV    = 4,
    parameter int BOUNCE     = 3,
    parameter int ACCEL_DIV  = 8,
    parameter int TURN_DELAY = 2,
    parameter int SLOW_COLOR = 6,
    parameter int SLOW_MAX   = 2,
    parameter int HIT_R2     = 36,
    parameter int HIT_CD     = 30,
    parameter int WALL_CD    = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              state,
    input  logic [1:0]              h_code,
    input  logic [1:0]              v_code,
    input  logic [3:0]              color,
    input  logic [10*NUM_OPP-1:0]   opp_x,
    input  logic [10*NUM_OPP-1:0]   opp_y,
    input  logic [NUM_OPP-1:0]      opp_valid,
    output logic [9:0]              pos_x,
    output logic [9:0]              pos_y,
    output logic [3:0]              angle_idx,
    output logic signed [7:0]       speed_out,
    output logic                    hit_pulse,
    output logic                    wall_pulse,
    output logic                    tick_done,
    output logic [2:0]              hit_idx,
    output logic                    busy
);
    localparam int AW = 10 + FRAC_BITS;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic signed [AW-1:0] AX0 = AW'(START_X * (1 << FRAC_BITS));
    localparam logic signed [AW-1:0] AY0 = AW'(START_Y * (1 << FRAC_BITS));
    localparam logic signed [7:0] S_FMAX = 8'(MAX_FWD);
    localparam logic signed [7:0] S_RMAX = 8'(-MAX_REV);
    localparam logic signed [7:0] S_SMAX = 8'(SLOW_MAX);
    localparam logic signed [7:0] S_SMIN = 8'(-SLOW_MAX);
    localparam logic signed [7:0] S_BP = 8'(BOUNCE);
    localparam logic signed [7:0] S_BN = 8'(-BOUNCE);

    phy_st_e r_st, w_nst;
    logic [TW-1:0] r_tick;
    logic [2:0] r_idx, r_hit_idx;
    logic r_found;
    logic signed [AW-1:0] r_ax, r_ay, w_nx, w_ny;
    logic [9:0] r_px, r_py, w_ox, w_oy;
    logic signed [7:0] r_spd, w_lo, w_hi, w_fric, w_step, w_tn, w_tf, w_bnc;
    logic [5:0] r_ang;
    logic [7:0] r_tcnt, r_cd;
    logic [15:0] r_adiv;
    logic signed [10:0] w_dx, w_dy;
    logic signed [21:0] w_ex, w_ey;
    logic [21:0] w_d2;
    logic w_tick, w_clr, w_hit, w_wall, w_a0, w_slow, w_mv, w_turn;
    dir_t w_dir;

    dir_lut16 u_dir (.i_idx(r_ang[5:2]), .o_dir(w_dir));

    // datapath: tick detect, distance test for the scanned opponent, speed targets and movement
    always_comb begin
        w_tick = r_tick == TW'(TICK_DIV - 1);
        w_clr = rst || (r_st == ST_WAIT && state == GS_IDLE);
        w_ox = opp_x[10*r_idx +: 10];
        w_oy = opp_y[10*r_idx +: 10];
        w_dx = $signed({1'b0, r_px}) - $signed({1'b0, w_ox});
        w_dy = $signed({1'b0, r_py}) - $signed({1'b0, w_oy});
        w_ex = 22'(w_dx);
        w_ey = 22'(w_dy);
        w_d2 = w_ex * w_ex + w_ey * w_ey;
        w_hit = opp_valid[r_idx] && w_d2 < 22'(HIT_R2);
        w_wall = r_px < 10'(WALL_M) || r_px > 10'(MAP_W - WALL_M) || r_py < 10'(WALL_M) || r_py > 10'(MAP_H - WALL_M);
        w_a0 = r_adiv == '0;
        w_slow = color == 4'(SLOW_COLOR);
        w_lo = w_slow ? S_SMIN : 8'sh80;
        w_hi = w_slow ? S_SMAX : 8'sh7f;
        w_fric = r_spd > 8'sd0 ? r_spd - 8'sd1 : r_spd < 8'sd0 ? r_spd + 8'sd1 : 8'sd0;
        w_step = v_code == 2'd1 ? (r_spd < S_FMAX ? r_spd + 8'sd1 : S_FMAX) :
                 v_code == 2'd2 ? (r_spd > S_RMAX ? r_spd - 8'sd1 : S_RMAX) : w_fric;
        w_tn = clamp8(w_a0 ? w_step : r_spd, w_lo, w_hi);
        w_tf = clamp8(w_a0 ? w_fric : r_spd, w_lo, w_hi);
        w_bnc = r_spd >= 8'sd0 ? S_BN : S_BP;
        w_mv = r_cd != '0 || (!r_found && !w_wall);
        w_nx = r_ax + ((AW'(r_spd) * AW'($signed(w_dir.x))) >>> 2);
        w_ny = r_ay + ((AW'(r_spd) * AW'($signed(w_dir.y))) >>> 2);
        w_turn = h_code == 2'd1 || h_code == 2'd2;
    end

    // FSM state register
    always_ff @(posedge clk)
        r_st <= w_clr ? ST_WAIT : w_nst;

    // FSM next state: a tick starts a scan of NUM_OPP cycles, then one apply cycle
    always_comb begin
        w_nst = r_st;
        case (r_st)
            ST_WAIT: if (w_tick && state == GS_RACING) w_nst = ST_SCAN;
            ST_SCAN: if (r_idx == 3'(NUM_OPP - 1)) w_nst = ST_APPLY;
            default: w_nst = ST_WAIT;
        endcase
    end

    // FSM outputs: pulses only in apply, and only when no cooldown is running
    always_comb begin
        busy = r_st != ST_WAIT;
        tick_done = r_st == ST_APPLY;
        hit_pulse = tick_done && r_cd == '0 && r_found;
        wall_pulse = tick_done && r_cd == '0 && !r_found && w_wall;
    end

    // free-running game tick divider
    always_ff @(posedge clk)
        r_tick <= w_clr || w_tick ? '0 : r_tick + 1'b1;

    // opponent scan: one opponent per cycle, keep the lowest index that hit
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_idx <= '0;
            r_found <= 1'b0;
            r_hit_idx <= '0;
        end else if (r_st == ST_WAIT) begin
            r_idx <= '0;
            r_found <= 1'b0;
        end else if (r_st == ST_SCAN) begin
            r_idx <= r_idx + 3'd1;
            if (w_hit && !r_found && r_cd == '0) begin
                r_found <= 1'b1;
                r_hit_idx <= r_idx;
            end
        end
    end

    // apply: steering, speed update with cooldown/hit/wall priority, and movement
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_ax <= AX0;
            r_ay <= AY0;
            r_px <= 10'(START_X);
            r_py <= 10'(START_Y);
            r_spd <= '0;
            r_ang <= '0;
            r_tcnt <= '0;
            r_cd <= '0;
            r_adiv <= '0;
        end else if (r_st == ST_APPLY) begin
            r_adiv <= r_adiv == 16'(ACCEL_DIV - 1) ? '0 : r_adiv + 16'd1;
            r_ang <= w_turn && r_tcnt == '0 ? (h_code == 2'd1 ? r_ang - 6'd1 : r_ang + 6'd1) : r_ang;
            r_tcnt <= !w_turn ? '0 : r_tcnt == '0 ? 8'(TURN_DELAY) : r_tcnt - 8'd1;
            r_spd <= r_cd != '0 ? w_tf : (r_found || w_wall) ? w_bnc : w_tn;
            r_cd <= r_cd != '0 ? r_cd - 8'd1 : r_found ? 8'(HIT_CD) : w_wall ? 8'(WALL_CD) : '0;
            if (w_mv) begin
                r_ax <= w_nx;
                r_ay <= w_ny;
                r_px <= w_nx[AW-1:FRAC_BITS] + {9'd0, w_nx[FRAC_BITS-1]};
                r_py <= w_ny[AW-1:FRAC_BITS] + {9'd0, w_ny[FRAC_BITS-1]};
            end
        end
    end

    assign pos_x = r_px;
    assign pos_y = r_py;
    assign angle_idx = r_ang[5:2];
    assign speed_out = r_spd;
    assign hit_idx = r_hit_idx;
endmodule

// File: tb/tb_car_physics_multi.sv
// tb_car_physics_multi: directed vectors for car_physics_multi with hand-computed expectations
module tb_car_physics_multi;
    logic clk = 0, rst = 1;
    logic [2:0] st_a = 0, st_b = 0;
    logic [1:0] h_code = 0, v_code = 0;
    logic [3:0] color = 0;
    logic [29:0] opp_x = 0, opp_y = 0;
    logic [2:0] opp_valid = 0;
    logic [9:0] a_px, a_py, b_px, b_py;
    logic [3:0] a_ang, b_ang;
    logic signed [7:0] a_spd, b_spd;
    logic a_hit, a_wall, a_td, a_busy, b_hit, b_wall, b_td, b_busy;
    logic [2:0] a_hidx, b_hidx;
    int n_vec = 0, n_err = 0;
    int cap_hit, cap_wall, cap_hidx, cap_scan, cnt;
    int xt [9] = '{163, 163, 164, 164, 164, 164, 165, 165, 165};

    car_physics_multi #(.TICK_DIV(10), .START_X(160), .START_Y(120)) dut (
        .clk(clk), .rst(rst), .state(st_a), .h_code(h_code), .v_code(v_code), .color(color),
        .opp_x(opp_x), .opp_y(opp_y), .opp_valid(opp_valid),
        .pos_x(a_px), .pos_y(a_py), .angle_idx(a_ang), .speed_out(a_spd),
        .hit_pulse(a_hit), .wall_pulse(a_wall), .tick_done(a_td), .hit_idx(a_hidx), .busy(a_busy));

    car_physics_multi #(.TICK_DIV(10), .START_X(4), .START_Y(120)) dut_wall (
        .clk(clk), .rst(rst), .state(st_b), .h_code(h_code), .v_code(v_code), .color(color),
        .opp_x(opp_x), .opp_y(opp_y), .opp_valid(opp_valid),
        .pos_x(b_px), .pos_y(b_py), .angle_idx(b_ang), .speed_out(b_spd),
        .hit_pulse(b_hit), .wall_pulse(b_wall), .tick_done(b_td), .hit_idx(b_hidx), .busy(b_busy));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_apply(input bit use_b);
        bit seen = 0;
        cap_scan = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (use_b ? b_td : a_td) begin
                seen = 1;
                cap_hit = int'(use_b ? b_hit : a_hit);
                cap_wall = int'(use_b ? b_wall : a_wall);
                cap_hidx = int'(use_b ? b_hidx : a_hidx);
            end else if (use_b ? b_busy : a_busy) cap_scan++;
        end
        chk("apply_seen", int'(seen), 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_px", a_px, 160);
        chk("rst_py", a_py, 120);
        chk("rst_spd", a_spd, 0);
        chk("rst_ang", a_ang, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_hidx", a_hidx, 0);
        chk("rst_b_px", b_px, 4);

        st_b = 4;
        wait_apply(1);
        chk("b_wall", cap_wall, 1);
        chk("b_hit", cap_hit, 0);
        chk("b_scan_len", cap_scan, 3);
        chk("b_bounce_spd", b_spd, -3);
        chk("b_px_held", b_px, 4);
        cnt = 0;
        for (int i = 2; i <= 21; i++) begin
            wait_apply(1);
            cnt += cap_wall;
        end
        chk("b_cooldown_quiet", cnt, 0);
        wait_apply(1);
        chk("b_wall_again", cap_wall, 1);
        chk("b_bounce_pos", b_spd, 3);
        chk("b_py", b_py, 123);
        st_b = 0;

        st_a = 4;
        v_code = 1;
        for (int i = 1; i <= 48; i++) begin
            wait_apply(0);
            if (i == 1) chk("scan_len", cap_scan, 3);
            chk($sformatf("accel_spd_t%0d", i), a_spd, i >= 41 ? 6 : (i - 1) / 8 + 1);
        end
        chk("north_py", a_py, 110);
        chk("north_px", a_px, 160);

        st_a = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        v_code = 0;
        h_code = 2;
        st_a = 4;
        for (int i = 1; i <= 46; i++) begin
            wait_apply(0);
            if (i == 45) chk("ang_t45", a_ang, 3);
        end
        chk("ang_t46", a_ang, 4);
        chk("steer_spd", a_spd, 0);
        chk("steer_px", a_px, 160);
        h_code = 0;
        v_code = 1;
        for (int i = 47; i <= 81; i++) begin
            wait_apply(0);
            if (i >= 73) begin
                chk($sformatf("east_px_t%0d", i), a_px, xt[i-73]);
                chk($sformatf("east_spd_t%0d", i), a_spd, i < 81 ? 4 : 5);
            end
        end
        chk("east_py", a_py, 120);

        opp_x = {10'd165, 10'd300, 10'd20};
        opp_y = {10'd120, 10'd200, 10'd20};
        opp_valid = 3'b011;
        wait_apply(0);
        chk("masked_hit", cap_hit, 0);
        chk("masked_wall", cap_wall, 0);
        chk("masked_spd", a_spd, 5);
        chk("masked_px", a_px, 165);
        opp_valid = 3'b111;
        wait_apply(0);
        chk("hit_pulse", cap_hit, 1);
        chk("hit_idx", cap_hidx, 2);
        chk("hit_latency", cap_scan, 3);
        chk("hit_spd", a_spd, -3);
        chk("hit_px_held", a_px, 165);
        opp_x[9:0] = 10'd163;
        opp_y[9:0] = 10'd120;
        cnt = 0;
        for (int i = 84; i <= 113; i++) begin
            wait_apply(0);
            cnt += cap_hit;
        end
        chk("cooldown_quiet", cnt, 0);
        chk("cooldown_spd", a_spd, 0);
        chk("cooldown_px", a_px, 163);
        wait_apply(0);
        chk("rehit_pulse", cap_hit, 1);
        chk("rehit_lowest_idx", cap_hidx, 0);
        chk("rehit_spd", a_spd, -3);

        st_a = 3;
        cnt = 0;
        repeat (10000) begin
            @(negedge clk);
            cnt += int'(a_td || a_busy);
        end
        chk("pause_idle", cnt, 0);
        chk("pause_px", a_px, 163);
        chk("pause_py", a_py, 120);
        chk("pause_spd", a_spd, -3);
        chk("pause_ang", a_ang, 4);

        st_a = 4;
        for (int n = 0; n < 40 && !a_busy; n++) @(negedge clk);
        chk("scan_started", a_busy, 1);
        @(negedge clk);
        rst = 1;
        cnt = 0;
        @(negedge clk);
        cnt += int'(a_td);
        rst = 0;
        st_a = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(a_td);
        end
        chk("abort_no_apply", cnt, 0);
        chk("abort_px", a_px, 160);
        chk("abort_py", a_py, 120);
        chk("abort_spd", a_spd, 0);
        chk("abort_ang", a_ang, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_hidx", a_hidx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
